sound_scheduler: RTL and testbench

- Sequences the shared audio player. The player has one `play` pulse, one 3-bit `soundchoice` select and one PWM output, so only one sound can play at a time.
- Game logic raises per-event request pulses. The block latches them, picks one by fixed priority, pulses `play`, and holds `soundchoice` for the sound's duration.
- Optionally pre-empts the current sound with a higher-priority one. Inserts a silent gap between sounds.
- Sits between the game FSM / software registers and the audio player.

---
 rtl/audio_pkg.sv | 48 ++++
 rtl/sound_prio_pick.sv | 22 ++
 rtl/sound_scheduler.sv | 124 ++++++++++++
 tb/tb_sound_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio sequencing blocks: FSM states, sound IDs,
// default durations and the fixed launch priority order.
package audio_pkg;

    typedef enum logic [1:0] {IDLE, LAUNCH, PLAY, GAP} state_t;

    localparam logic [2:0] SND_NONE     = 3'd0;
    localparam logic [2:0] SND_CHOMP    = 3'd1;
    localparam logic [2:0] SND_PLACE    = 3'd2;
    localparam logic [2:0] SND_TRAVEL   = 3'd3;
    localparam logic [2:0] SND_MOVE     = 3'd4;
    localparam logic [2:0] SND_GAMEOVER = 3'd5;

    localparam int unsigned DEF_DUR_CHOMP    = 32'd49001706;
    localparam int unsigned DEF_DUR_PLACE    = 32'd75485829;
    localparam int unsigned DEF_DUR_TRAVEL   = 32'd197952804;
    localparam int unsigned DEF_DUR_MOVE     = 32'd96007023;
    localparam int unsigned DEF_DUR_GAMEOVER = 32'd321007680;
    localparam int unsigned DEF_GAP_CYC      = 32'd1000;

    // Highest priority in the top three bits, lowest in the bottom three.
    localparam logic [14:0] PRIO_ORDER = {SND_GAMEOVER, SND_TRAVEL, SND_PLACE, SND_CHOMP, SND_MOVE};

    function automatic logic [2:0] prio_at(input int k);
        return PRIO_ORDER[3*(4-k) +: 3];
    endfunction

    // Request bit for a sound ID; SND_NONE maps to no bit.
    function automatic logic [4:0] snd_bit(input logic [2:0] id);
        logic [4:0] b;
        b = 5'b00001 << (id - 3'd1);
        return b;
    endfunction

    // Request bits whose sound outranks cur.
    function automatic logic [4:0] higher_mask(input logic [2:0] cur);
        logic [4:0] m;
        logic found;
        m = '0;
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (prio_at(k) == cur) found = 1'b1;
            else if (!found) m = m | snd_bit(prio_at(k));
        end
        return m;
    endfunction

endpackage

// File: rtl/sound_prio_pick.sv
// Fixed-priority encoder: request bit vector to {valid, winning sound ID}.
module sound_prio_pick
    import audio_pkg::*;
(
    input  logic [4:0] pending,
    output logic       valid,
    output logic [2:0] id
);

    // Walk lowest to highest so the highest-priority hit is written last.
    always_comb begin
        valid = 1'b0;
        id    = SND_NONE;
        for (int k = 4; k >= 0; k--) begin
            if ((pending & snd_bit(prio_at(k))) != 5'b0) begin
                valid = 1'b1;
                id    = prio_at(k);
            end
        end
    end

endmodule

// File: rtl/sound_scheduler.sv
// Sequences the shared audio player: latches request pulses, launches one
// sound at a time by priority, optionally pre-empts, and inserts a silent gap.
module sound_scheduler
    import audio_pkg::*;
#(
    parameter int unsigned DUR_CHOMP    = DEF_DUR_CHOMP,
    parameter int unsigned DUR_PLACE    = DEF_DUR_PLACE,
    parameter int unsigned DUR_TRAVEL   = DEF_DUR_TRAVEL,
    parameter int unsigned DUR_MOVE     = DEF_DUR_MOVE,
    parameter int unsigned DUR_GAMEOVER = DEF_DUR_GAMEOVER,
    parameter int unsigned GAP_CYC      = DEF_GAP_CYC,
    parameter bit          PREEMPT      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req,
    input  logic       stop,
    input  logic       mute,
    output logic       play,
    output logic [2:0] soundchoice,
    output logic       busy,
    output logic [4:0] pending,
    output logic [1:0] state_dbg
);

    state_t      state, state_next;
    logic [31:0] counter, counter_next;
    logic [2:0]  choice_next, launch_id;
    logic [4:0]  clr, pending_next;
    logic        win_valid, pre_valid, do_launch;
    logic [2:0]  win_id, pre_id;

    function automatic logic [31:0] dur_m1(input logic [2:0] id);
        case (id)
            SND_CHOMP:    return 32'(DUR_CHOMP - 1);
            SND_PLACE:    return 32'(DUR_PLACE - 1);
            SND_TRAVEL:   return 32'(DUR_TRAVEL - 1);
            SND_MOVE:     return 32'(DUR_MOVE - 1);
            SND_GAMEOVER: return 32'(DUR_GAMEOVER - 1);
            default:      return 32'd0;
        endcase
    endfunction

    sound_prio_pick u_win (.pending(pending), .valid(win_valid), .id(win_id));

    // Same encoder restricted to sounds that outrank the one playing.
    sound_prio_pick u_pre (
        .pending(pending & higher_mask(soundchoice)),
        .valid  (pre_valid),
        .id     (pre_id)
    );

    always_comb begin
        state_next   = state;
        counter_next = counter;
        choice_next  = soundchoice;
        clr          = 5'b0;
        do_launch    = 1'b0;
        launch_id    = SND_NONE;
        case (state)
            IDLE: begin
                if (win_valid && !mute) begin
                    do_launch = 1'b1;
                    launch_id = win_id;
                end
            end
            LAUNCH: state_next = PLAY;
            PLAY: begin
                if (PREEMPT && pre_valid && !mute) begin
                    do_launch = 1'b1;
                    launch_id = pre_id;
                end else if (counter == 32'd0) begin
                    choice_next = SND_NONE;
                    if (GAP_CYC == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = GAP;
                        counter_next = 32'(GAP_CYC - 1);
                    end
                end else begin
                    counter_next = counter - 32'd1;
                end
            end
            GAP: begin
                if (counter == 32'd0) state_next = IDLE;
                else counter_next = counter - 32'd1;
            end
            default: state_next = IDLE;
        endcase
        if (do_launch) begin
            state_next   = LAUNCH;
            choice_next  = launch_id;
            clr          = snd_bit(launch_id);
            counter_next = dur_m1(launch_id);
        end
        // A new request in the clear cycle survives, so the sound replays.
        pending_next = (pending & ~clr) | req;
        if (stop) begin
            state_next   = IDLE;
            choice_next  = SND_NONE;
            counter_next = 32'd0;
            pending_next = 5'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= 32'd0;
            soundchoice <= SND_NONE;
            pending     <= 5'b0;
        end else begin
            state       <= state_next;
            counter     <= counter_next;
            soundchoice <= choice_next;
            pending     <= pending_next;
        end
    end

    assign play      = (state == LAUNCH);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: vector table plus hand sequences, with a launch
// scoreboard on two instances (pre-emption enabled and disabled).
module tb_sound_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req = 5'b0;
    logic       stop = 1'b0;
    logic       mute = 1'b0;

    logic       play, np_play, busy, np_busy;
    logic [2:0] sc, np_sc;
    logic [4:0] pend, np_pend;
    logic [1:0] st, np_st;

    int tests = 0;
    int fails = 0;

    logic [2:0] exp_q[$];
    logic [2:0] np_exp_q[$];
    logic [2:0] mon_e, np_mon_e;

    typedef struct {
        logic [4:0] req;
        logic       stop;
        logic       mute;
        int         n;
        logic       play;
        logic [2:0] sc;
        logic       busy;
        logic [4:0] pend;
    } vec_t;
    vec_t vecs[$];

    sound_scheduler #(
        .DUR_CHOMP(20), .DUR_PLACE(30), .DUR_TRAVEL(40), .DUR_MOVE(50),
        .DUR_GAMEOVER(60), .GAP_CYC(4), .PREEMPT(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .stop(stop), .mute(mute),
        .play(play), .soundchoice(sc), .busy(busy), .pending(pend), .state_dbg(st)
    );

    sound_scheduler #(
        .DUR_CHOMP(20), .DUR_PLACE(30), .DUR_TRAVEL(40), .DUR_MOVE(50),
        .DUR_GAMEOVER(60), .GAP_CYC(4), .PREEMPT(1'b0)
    ) dut_np (
        .clk(clk), .rst(rst), .req(req), .stop(stop), .mute(mute),
        .play(np_play), .soundchoice(np_sc), .busy(np_busy), .pending(np_pend), .state_dbg(np_st)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step(input logic [4:0] r, input logic s, input logic m);
        req  = r;
        stop = s;
        mute = m;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic p, input logic [2:0] c,
                              input logic b, input logic [4:0] pd);
        check(name, {22'b0, play, sc, busy, pend}, {22'b0, p, c, b, pd});
    endtask

    task automatic check_np(input string name, input logic p, input logic [2:0] c,
                            input logic b, input logic [4:0] pd);
        check(name, {22'b0, np_play, np_sc, np_busy, np_pend}, {22'b0, p, c, b, pd});
    endtask

    task automatic push(input logic [2:0] id);
        exp_q.push_back(id);
        np_exp_q.push_back(id);
    endtask

    task automatic add(input logic [4:0] r, input logic s, input logic m, input int n,
                       input logic p, input logic [2:0] c, input logic b, input logic [4:0] pd);
        vec_t v;
        v.req = r; v.stop = s; v.mute = m; v.n = n;
        v.play = p; v.sc = c; v.busy = b; v.pend = pd;
        vecs.push_back(v);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 1000; i++) begin
            if (!busy && !np_busy && pend == 5'b0 && np_pend == 5'b0) break;
            step(5'b0, 1'b0, 1'b0);
        end
        check(name, {20'b0, busy, np_busy, pend, np_pend}, 32'd0);
    endtask

    // Scoreboard: every play pulse must match the next expected launch.
    always @(negedge clk) begin
        if (!rst && play) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL launch: got unexpected play with soundchoice %0d, expected none", sc);
            end else begin
                mon_e = exp_q.pop_front();
                if (sc !== mon_e) begin
                    fails++;
                    $display("FAIL launch: got soundchoice %0d expected %0d", sc, mon_e);
                end
            end
        end
        if (!rst && np_play) begin
            tests++;
            if (np_exp_q.size() == 0) begin
                fails++;
                $display("FAIL np_launch: got unexpected play with soundchoice %0d, expected none", np_sc);
            end else begin
                np_mon_e = np_exp_q.pop_front();
                if (np_sc !== np_mon_e) begin
                    fails++;
                    $display("FAIL np_launch: got soundchoice %0d expected %0d", np_sc, np_mon_e);
                end
            end
        end
    end

    initial begin
        int cnt;

        // Reset state
        rst = 1'b1;
        step(5'b0, 1'b0, 1'b0);
        step(5'b11111, 1'b0, 1'b0);
        check_outs("reset", 1'b0, 3'd0, 1'b0, 5'b0);
        check_np("np_reset", 1'b0, 3'd0, 1'b0, 5'b0);
        rst = 1'b0;

        // Single chomp: latency, duration, gap
        add(5'b00001, 0, 0, 1,  0, 3'd0, 0, 5'b00001);
        add(5'b00000, 0, 0, 1,  1, 3'd1, 1, 5'b00000);
        add(5'b00000, 0, 0, 20, 0, 3'd1, 1, 5'b00000);
        add(5'b00000, 0, 0, 4,  0, 3'd0, 1, 5'b00000);
        add(5'b00000, 0, 0, 2,  0, 3'd0, 0, 5'b00000);
        // Chomp + move together: chomp first, move after the gap
        add(5'b01001, 0, 0, 1,  0, 3'd0, 0, 5'b01001);
        add(5'b00000, 0, 0, 1,  1, 3'd1, 1, 5'b01000);
        add(5'b00000, 0, 0, 20, 0, 3'd1, 1, 5'b01000);
        add(5'b00000, 0, 0, 4,  0, 3'd0, 1, 5'b01000);
        add(5'b00000, 0, 0, 1,  0, 3'd0, 0, 5'b01000);
        add(5'b00000, 0, 0, 1,  1, 3'd4, 1, 5'b00000);
        add(5'b00000, 0, 0, 50, 0, 3'd4, 1, 5'b00000);
        add(5'b00000, 0, 0, 4,  0, 3'd0, 1, 5'b00000);
        add(5'b00000, 0, 0, 2,  0, 3'd0, 0, 5'b00000);
        // Request together with stop is discarded
        add(5'b00001, 1, 0, 1,  0, 3'd0, 0, 5'b00000);
        add(5'b00000, 0, 0, 2,  0, 3'd0, 0, 5'b00000);
        // Mute holds pending, release launches
        add(5'b00010, 0, 1, 1,  0, 3'd0, 0, 5'b00010);
        add(5'b00000, 0, 1, 3,  0, 3'd0, 0, 5'b00010);
        add(5'b00000, 0, 0, 1,  1, 3'd2, 1, 5'b00000);
        add(5'b00000, 0, 0, 30, 0, 3'd2, 1, 5'b00000);
        add(5'b00000, 0, 0, 4,  0, 3'd0, 1, 5'b00000);
        add(5'b00000, 0, 0, 1,  0, 3'd0, 0, 5'b00000);
        // Mute during play lets the current sound finish
        add(5'b00001, 0, 0, 1,  0, 3'd0, 0, 5'b00001);
        add(5'b00000, 0, 0, 1,  1, 3'd1, 1, 5'b00000);
        add(5'b00000, 0, 1, 20, 0, 3'd1, 1, 5'b00000);
        add(5'b00000, 0, 1, 4,  0, 3'd0, 1, 5'b00000);
        add(5'b00000, 0, 0, 1,  0, 3'd0, 0, 5'b00000);

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].n; r++) begin
                if (vecs[i].play) push(vecs[i].sc);
                step(vecs[i].req, vecs[i].stop, vecs[i].mute);
                check_outs($sformatf("vec%0d.%0d", i, r), vecs[i].play, vecs[i].sc,
                           vecs[i].busy, vecs[i].pend);
            end
        end

        // Gameover pre-empts chomp; without pre-emption it waits for chomp + gap
        push(3'd1);
        push(3'd5);
        step(5'b00001, 1'b0, 1'b0);
        step(5'b00000, 1'b0, 1'b0);
        check_outs("t3_launch", 1'b1, 3'd1, 1'b1, 5'b0);
        repeat (5) step(5'b00000, 1'b0, 1'b0);
        step(5'b10000, 1'b0, 1'b0);
        check_outs("t3_req", 1'b0, 3'd1, 1'b1, 5'b10000);
        check_np("t3_np_req", 1'b0, 3'd1, 1'b1, 5'b10000);
        step(5'b00000, 1'b0, 1'b0);
        check_outs("t3_preempt", 1'b1, 3'd5, 1'b1, 5'b0);
        check_np("t3_np_hold", 1'b0, 3'd1, 1'b1, 5'b10000);
        cnt = 1;
        for (int i = 0; i < 40 && !np_play; i++) begin
            step(5'b00000, 1'b0, 1'b0);
            cnt++;
        end
        check("t3_np_delay", cnt, 32'd20);
        drain("t3_drain");

        // Lower priority request during travel only queues
        push(3'd3);
        push(3'd1);
        step(5'b00100, 1'b0, 1'b0);
        step(5'b00000, 1'b0, 1'b0);
        check_outs("t4_launch", 1'b1, 3'd3, 1'b1, 5'b0);
        repeat (3) step(5'b00000, 1'b0, 1'b0);
        step(5'b00001, 1'b0, 1'b0);
        check_outs("t4_queued", 1'b0, 3'd3, 1'b1, 5'b00001);
        step(5'b00000, 1'b0, 1'b0);
        check_outs("t4_no_preempt", 1'b0, 3'd3, 1'b1, 5'b00001);
        drain("t4_drain");

        // Re-request in the clear cycle: chomp twice, gap in between
        push(3'd1);
        push(3'd1);
        step(5'b00001, 1'b0, 1'b0);
        step(5'b00001, 1'b0, 1'b0);
        check_outs("t5_launch", 1'b1, 3'd1, 1'b1, 5'b00001);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step(5'b00000, 1'b0, 1'b0);
            cnt++;
            if (play) break;
        end
        check("t5_spacing", cnt, 32'd26);
        drain("t5_drain");

        // Stop during play flushes everything
        push(3'd5);
        step(5'b10000, 1'b0, 1'b0);
        step(5'b00000, 1'b0, 1'b0);
        check_outs("t6_launch", 1'b1, 3'd5, 1'b1, 5'b0);
        repeat (3) step(5'b00000, 1'b0, 1'b0);
        step(5'b00110, 1'b0, 1'b0);
        check_outs("t6_pend", 1'b0, 3'd5, 1'b1, 5'b00110);
        step(5'b00000, 1'b1, 1'b0);
        check_outs("t6_stop", 1'b0, 3'd0, 1'b0, 5'b0);
        check_np("t6_np_stop", 1'b0, 3'd0, 1'b0, 5'b0);
        repeat (10) step(5'b00000, 1'b0, 1'b0);
        check("t6_quiet", {22'b0, busy, pend, np_busy, np_pend}, 32'd0);

        // Reset mid-play overrides a simultaneous request
        push(3'd1);
        step(5'b00001, 1'b0, 1'b0);
        step(5'b00000, 1'b0, 1'b0);
        repeat (3) step(5'b00000, 1'b0, 1'b0);
        rst = 1'b1;
        step(5'b00010, 1'b0, 1'b0);
        check_outs("rst_mid", 1'b0, 3'd0, 1'b0, 5'b0);
        check_np("np_rst_mid", 1'b0, 3'd0, 1'b0, 5'b0);
        rst = 1'b0;
        repeat (3) step(5'b00000, 1'b0, 1'b0);

        check("sb_empty", exp_q.size() + np_exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
